// File: rtl/cic_ctrl.sv
// -----------------------------------------------------------------------------
// cic_ctrl
//
// Sequencer and stream front/back end for a 1-bit-in, DATA_W-bit-out CIC
// decimation filter.
//   * Generates the filter's input strobes from a raw PDM bit at a
//     programmable rate (one strobe every div_q+1 cycles).
//   * Drives the filter clock-enable and active-low reset. Every start passes
//     through a 2-cycle FLUSH.
//   * Discards the first SETTLE good filter outputs after each start.
//   * Buffers accepted filter outputs in a show-ahead FIFO with a
//     valid/ready handshake toward the downstream audio logic.
//
// Optional feature macro: CIC_CTRL_STATS_EN
//   defined     -> sample_cnt counts FIFO writes made in RUN. It saturates at
//                  0xFFFF and clears in FLUSH and on reset.
//   not defined -> sample_cnt is tied to zero.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   enable          run request (level)
//   div             strobe period minus 1, captured on FLUSH entry
//   pdm_in          raw modulator bit
//   cic_clken       filter clock enable
//   cic_reset_n     filter reset, active low (asserted during FLUSH only)
//   cic_in_data     bit presented to the filter with the strobe
//   cic_in_valid    input strobe toward the filter
//   cic_in_ready    filter input ready
//   cic_out_data    filter output sample
//   cic_out_valid   filter output valid
//   cic_out_error   filter error code; nonzero marks a bad sample
//   cic_out_ready   FIFO not full
//   m_data          FIFO head (zero while the FIFO is empty)
//   m_valid         FIFO not empty
//   m_ready         downstream accept
//   busy            sequencer not idle
//   in_miss         sticky: a strobe was issued while cic_in_ready was low
//   overrun         sticky: a good output arrived in RUN while the FIFO was full
//   err             sticky: an output arrived with a nonzero error code
//   sample_cnt      forwarded-sample count (see macro above)
// -----------------------------------------------------------------------------
module cic_ctrl #(
    parameter int DATA_W     = 16,
    parameter int DIV_W      = 8,
    parameter int SETTLE     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic              pdm_in,
    output logic              cic_clken,
    output logic              cic_reset_n,
    output logic              cic_in_data,
    output logic              cic_in_valid,
    input  logic              cic_in_ready,
    input  logic [DATA_W-1:0] cic_out_data,
    input  logic              cic_out_valid,
    input  logic [1:0]        cic_out_error,
    output logic              cic_out_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              in_miss,
    output logic              overrun,
    output logic              err,
    output logic [15:0]       sample_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Value of settle_cnt at which the next good output ends SETTLE.
    localparam logic [SET_W-1:0] SETTLE_LAST = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic               flush_cnt_q;   // 0 = first FLUSH cycle, 1 = second
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [SET_W-1:0]   settle_cnt_q;
    logic               in_data_q;
    logic               in_miss_q;
    logic               overrun_q;
    logic               err_q;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic active;
    logic div_tc;
    logic strobe;
    logic out_good;
    logic out_bad;
    logic fifo_full;
    logic fifo_empty;
    logic wr_en;
    logic rd_en;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    assign active     = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign div_tc     = (div_cnt_q == div_q);
    // Gating with enable suppresses the strobe in the cycle the run request
    // drops, so no strobe is issued on the way back to IDLE.
    assign strobe     = active && enable && div_tc;

    assign out_good   = cic_out_valid && (cic_out_error == 2'b00);
    assign out_bad    = cic_out_valid && (cic_out_error != 2'b00);

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full FIFO refuses the write even when a pop happens in the same cycle.
    assign wr_en      = (state_q == ST_RUN) && out_good && !fifo_full;
    assign rd_en      = !fifo_empty && m_ready;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // that no path leaves a variable unassigned (which would infer a latch).
        state_d     = state_q;
        cic_clken   = 1'b1;
        cic_reset_n = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cic_clken = 1'b0;
                if (enable) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                cic_reset_n = 1'b0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (flush_cnt_q) begin
                    state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (out_good && (settle_cnt_q == SETTLE_LAST)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Divider, settle counter, input data register and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_q  <= 1'b0;
            div_q        <= '0;
            div_cnt_q    <= '0;
            settle_cnt_q <= '0;
            in_data_q    <= 1'b0;
            in_miss_q    <= 1'b0;
            overrun_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            flush_cnt_q <= (state_q == ST_FLUSH) && !flush_cnt_q;

            // The rate is frozen for the whole run once FLUSH is entered.
            if ((state_q == ST_FLUSH) && !flush_cnt_q) begin
                div_q <= div;
            end

            // Free-running 0..div_q counter while the filter is running;
            // held at zero otherwise so each start begins a fresh period.
            if (active) begin
                div_cnt_q <= div_tc ? '0 : div_cnt_q + DIV_W'(1);
            end else begin
                div_cnt_q <= '0;
            end

            if (state_q == ST_FLUSH) begin
                settle_cnt_q <= '0;
            end else if ((state_q == ST_SETTLE) && out_good) begin
                settle_cnt_q <= settle_cnt_q + SET_W'(1);
            end

            // pdm_in is captured on every edge that leads into a running
            // cycle, so the bit beside a strobe is the one sampled just
            // before it.
            if ((state_d == ST_SETTLE) || (state_d == ST_RUN)) begin
                in_data_q <= pdm_in;
            end

            if (state_q == ST_FLUSH) begin
                in_miss_q <= 1'b0;
                overrun_q <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                if (strobe && !cic_in_ready) begin
                    in_miss_q <= 1'b1;
                end
                if (active && out_bad) begin
                    err_q <= 1'b1;
                end
                if ((state_q == ST_RUN) && out_good && fifo_full) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO (show-ahead)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count are
    // reset, and m_data is masked while empty so stale words never leak out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= cic_out_data;
        end
    end

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef CIC_CTRL_STATS_EN
    logic [15:0] sample_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_FLUSH)) begin
            sample_cnt_q <= '0;
        end else if (wr_en && (sample_cnt_q != 16'hFFFF)) begin
            sample_cnt_q <= sample_cnt_q + 16'd1;
        end
    end

    assign sample_cnt = sample_cnt_q;
`else
    assign sample_cnt = 16'h0000;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cic_in_valid  = strobe;
    assign cic_in_data   = in_data_q;
    assign cic_out_ready = !fifo_full;
    assign m_valid       = !fifo_empty;
    assign m_data        = fifo_empty ? '0 : mem[rd_ptr_q];
    assign busy          = (state_q != ST_IDLE);
    assign in_miss       = in_miss_q;
    assign overrun       = overrun_q;
    assign err           = err_q;

endmodule
